fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/rv_pkg.sv | 14 +
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_stage.sv | 99 +++++++++
 tb/tb_fetch_stage.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset PC default and
// the fixed instruction step.
package rv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_STEP       = 4;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: instruction-memory request/response, redirect from
// execute, and the instruction hand-off to decode.
interface fetch_stage_if #(
  parameter int unsigned WD = 32
) ();

  logic          imem_req;
  logic [WD-1:0] imem_addr;
  logic          imem_rvalid;
  logic [WD-1:0] imem_rdata;
  logic          redirect;
  logic [WD-1:0] redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [WD-1:0] instr;
  logic [WD-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular instruction buffer holding {instruction, pc} pairs; flush empties
// it and wins over a same-cycle push or pop.
module fetch_fifo #(
  parameter int unsigned WD    = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [WD-1:0] wr_instr,
  input  logic [WD-1:0] wr_pc,
  output logic [WD-1:0] rd_instr,
  output logic [WD-1:0] rd_pc,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WD-1:0] mem_instr [DEPTH];
  logic [WD-1:0] mem_pc    [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign rd_instr = mem_instr[rd_ptr];
  assign rd_pc    = mem_pc[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_instr[wr_ptr] <= wr_instr;
      mem_pc[wr_ptr]    <= wr_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding memory request at a time, responses
// buffered for decode, redirect flushes and discards in-flight data.
module fetch_stage
  import rv_pkg::*;
#(
  parameter int unsigned   WD       = 32,
  parameter int unsigned   DEPTH    = 2,
  parameter logic [WD-1:0] RESET_PC = WD'(RESET_PC_DEFAULT)
) (
  input  logic           clk,
  input  logic           rst,
  fetch_stage_if.master  bus
);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [WD-1:0] fetch_pc;
  logic [WD-1:0] req_pc;
  logic          run;
  logic          issue;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;

  // Holds requests off while reset is asserted; first request follows the
  // first clock edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // IDLE never has a request in flight, so occupancy + outstanding < DEPTH
  // reduces to the buffer not being full.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run && !bus.redirect && !fifo_full) begin
          issue     = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          push      = !bus.redirect;
          state_nxt = ST_IDLE;
        end else if (bus.redirect) begin
          state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (bus.imem_rvalid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      if (bus.redirect)  fetch_pc <= bus.redirect_pc & ~WD'(3);
      else if (issue)    fetch_pc <= fetch_pc + WD'(INSTR_STEP);
      if (issue)         req_pc   <= fetch_pc;
    end
  end

  assign pop             = !fifo_empty && bus.instr_ready;
  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = !fifo_empty;

  fetch_fifo #(
    .WD    (WD),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (bus.redirect),
    .wr_instr (bus.imem_rdata),
    .wr_pc    (req_pc),
    .rd_instr (bus.instr),
    .rd_pc    (bus.instr_pc),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: expected requests and
// instructions are queued per scenario and popped by a negedge monitor.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned cyc = 0;

  fetch_stage_if #(.WD(32)) bus ();

  fetch_stage #(
    .WD       (32),
    .DEPTH    (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        exp_ins  [$];
  logic [31:0] exp_addr [$];
  int unsigned pop_cyc  [$];
  int          total = 0;
  int          bad   = 0;
  bit          addr_chk, addr_strict, ins_chk;
  int unsigned lat       = 1;
  int unsigned stale_cyc = 32'hFFFF_FFFF;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic monitor_loop();
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst && addr_chk && bus.imem_req) begin
        if (exp_addr.size() != 0) check("imem_addr", bus.imem_addr, exp_addr.pop_front());
        else if (addr_strict) begin
          total++;
          bad++;
          $display("FAIL extra_req: got request %h want none", bus.imem_addr);
        end
      end
      if (rst && ins_chk && bus.instr_valid && bus.instr_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_ins.size() != 0) begin
          e = exp_ins.pop_front();
          check("instr_pc", bus.instr_pc, e.pc);
          check("instr", bus.instr, e.ins);
        end else begin
          total++;
          bad++;
          $display("FAIL extra_instr: got pc %h want none", bus.instr_pc);
        end
      end
    end
  endtask

  // Memory: captures a request mid-cycle, answers 'lat' cycles later.
  task automatic mem_loop();
    bit          pend = 1'b0;
    int unsigned cnt  = 0;
    logic [31:0] pa   = '0;
    forever begin
      @(negedge clk);
      if (!rst) pend = 1'b0;
      else if (bus.imem_req) begin
        pend = 1'b1;
        cnt  = lat;
        pa   = bus.imem_addr;
      end
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      if (cyc == stale_cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_BAD0;
      end else if (pend && rst) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mdata(pa);
          pend            = 1'b0;
        end
      end
    end
  endtask

  task automatic reset_dut();
    rst             = 1'b0;
    addr_chk        = 1'b0;
    ins_chk         = 1'b0;
    addr_strict     = 1'b0;
    exp_addr.delete();
    exp_ins.delete();
    pop_cyc.delete();
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic expect_ins(input logic [31:0] pc);
    ent_t e;
    e.pc  = pc;
    e.ins = mdata(pc);
    exp_ins.push_back(e);
  endtask

  task automatic release_dut();
    addr_chk = 1'b1;
    ins_chk  = 1'b1;
    rst      = 1'b1;
  endtask

  task automatic wait_ins_done(input string name, input int budget);
    int n = 0;
    while (exp_ins.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    addr_chk = 1'b0;
    ins_chk  = 1'b0;
    check({name, "_ins_left"}, exp_ins.size(), 0);
    check({name, "_addr_left"}, exp_addr.size(), 0);
  endtask

  task automatic wait_req(input logic [31:0] a, input int budget);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      hit = bus.imem_req && (bus.imem_addr == a);
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL wait_req: got no request for %h want one within %0d cycles", a, budget);
    end
  endtask

  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
    fork
      monitor_loop();
      mem_loop();
    join_none

    // Reset values, then streaming at latency 1: one instruction per 2 cycles.
    reset_dut();
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    lat = 1;
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
    expect_ins(32'h0); expect_ins(32'h4); expect_ins(32'h8);
    bus.instr_ready = 1'b1;
    release_dut();
    wait_ins_done("t1", 40);
    if (pop_cyc.size() >= 3) begin
      check("t1_gap01", pop_cyc[1] - pop_cyc[0], 32'd2);
      check("t1_gap12", pop_cyc[2] - pop_cyc[1], 32'd2);
    end else begin
      total++;
      bad++;
      $display("FAIL t1_pops: got %0d pops want 3", pop_cyc.size());
    end

    // Back-pressure: exactly two requests fill the buffer, then drain in order.
    reset_dut();
    lat         = 1;
    addr_strict = 1'b1;
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
    expect_ins(32'h0); expect_ins(32'h4); expect_ins(32'h8);
    release_dut();
    repeat (20) @(posedge clk);
    #1;
    check("t2_reqs_left", exp_addr.size(), 0);
    check("t2_valid", {31'b0, bus.instr_valid}, 32'd1);
    check("t2_head_pc", bus.instr_pc, 32'h0);
    addr_strict = 1'b0;
    exp_addr.push_back(32'h8);
    bus.instr_ready = 1'b1;
    wait_ins_done("t2", 40);

    // Redirect while 0x8 is outstanding (latency 3): response dropped.
    reset_dut();
    lat = 3;
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8); exp_addr.push_back(32'h100);
    expect_ins(32'h0); expect_ins(32'h4); expect_ins(32'h100);
    bus.instr_ready = 1'b1;
    release_dut();
    wait_req(32'h8, 60);
    @(posedge clk); #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    @(posedge clk); #1;
    bus.redirect    = 1'b0;
    wait_ins_done("t3", 60);

    // Redirect coinciding with the 0xC response.
    reset_dut();
    lat = 2;
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
    exp_addr.push_back(32'hC); exp_addr.push_back(32'h200);
    expect_ins(32'h0); expect_ins(32'h4); expect_ins(32'h8); expect_ins(32'h200);
    bus.instr_ready = 1'b1;
    release_dut();
    wait_req(32'hC, 60);
    @(posedge clk);
    @(posedge clk); #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    @(posedge clk); #1;
    bus.redirect    = 1'b0;
    check("t4_valid_after", {31'b0, bus.instr_valid}, 32'd0);
    wait_ins_done("t4", 60);

    // Flush of a full buffer; low address bits of redirect_pc ignored.
    reset_dut();
    lat = 1;
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h40); exp_addr.push_back(32'h44);
    expect_ins(32'h40); expect_ins(32'h44);
    release_dut();
    repeat (10) @(posedge clk);
    #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h43;
    @(posedge clk); #1;
    bus.redirect    = 1'b0;
    check("t5_flush", {31'b0, bus.instr_valid}, 32'd0);
    bus.instr_ready = 1'b1;
    wait_ins_done("t5", 40);

    // Address wrap past 0xFFFF_FFFC; redirect meets a same-cycle response.
    reset_dut();
    lat = 1;
    exp_addr.push_back(32'h0); exp_addr.push_back(32'hFFFF_FFFC); exp_addr.push_back(32'h0);
    expect_ins(32'hFFFF_FFFC); expect_ins(32'h0);
    bus.instr_ready = 1'b1;
    release_dut();
    wait_req(32'h0, 20);
    @(posedge clk); #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    bus.redirect    = 1'b0;
    wait_ins_done("t6", 40);

    // Reset while waiting; a stale response lands before the fresh request is accepted.
    reset_dut();
    lat = 10;
    bus.instr_ready = 1'b1;
    rst = 1'b1;
    wait_req(32'h0, 20);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("t7_rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("t7_rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("t7_rst_addr", bus.imem_addr, 32'h0);
    @(posedge clk); #1;
    lat = 1;
    exp_addr.push_back(32'h0);
    expect_ins(32'h0);
    addr_chk  = 1'b1;
    ins_chk   = 1'b1;
    stale_cyc = cyc + 1;
    rst       = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t7_stale_valid", {31'b0, bus.instr_valid}, 32'd0);
    wait_ins_done("t7", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
